fir_param_pipe: RTL and testbench

- Parametrised, fully pipelined direct-form FIR filter; next generation of the fixed 16-tap, 8-bit FIR.
- Generalises tap count and data, coefficient and output widths.
- Adds a valid-qualified stream so bubbles do not advance the delay line.
- Adds run-time coefficient loading through a shadow bank with atomic commit, plus a synchronous flush.
- Sits between the sample source (ROM/counter front end) and the output consumer.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_group_mac.sv | 43 ++++
 rtl/fir_param_pipe.sv | 152 +++++++++++++++
 tb/tb_fir_param_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared helpers and default coefficient table for the parametrised FIR.
// Used by fir_param_pipe and fir_group_mac.
package fir_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int acc_w(input int dw, input int cw,
                               input int taps);
    return dw + cw + clog2(taps);
  endfunction

  localparam int DEF_N = 16;

  localparam int DEF_COEF [DEF_N] = '{
    17, -41, 24, -58, -116, 86, -102, 58,
    -16, 127, 15, -9, -21, -74, -68, -48
  };

  function automatic int def_coef(input int k);
    return (k < DEF_N) ? DEF_COEF[k] : 0;
  endfunction

endpackage

// File: rtl/fir_group_mac.sv
// Four-tap slice: registered products, then a registered group sum.
// The valid bit follows the data and is killed by flush.
module fir_group_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic signed [DATA_W-1:0]         x [4],
  input  logic signed [COEF_W-1:0]         c [4],
  output logic                             out_valid,
  output logic signed [DATA_W+COEF_W+1:0]  out_sum
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;

  logic signed [PROD_W-1:0] prod_q [4];
  logic                     prod_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_v    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      for (int i = 0; i < 4; i++) prod_q[i] <= '0;
    end else begin
      prod_v    <= in_valid & ~flush;
      out_valid <= prod_v & ~flush;
      if (in_valid)
        for (int i = 0; i < 4; i++)
          prod_q[i] <= PROD_W'(x[i]) * PROD_W'(c[i]);
      if (prod_v)
        out_sum <= SUM_W'(prod_q[0]) + SUM_W'(prod_q[1])
                 + SUM_W'(prod_q[2]) + SUM_W'(prod_q[3]);
    end
  end

endmodule

// File: rtl/fir_param_pipe.sv
// Pipelined direct-form FIR with shadow/active coefficient banks.
// Define FIR_SAT_EN for output saturation and the sticky sat_flag.
module fir_param_pipe
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  input  logic                      coef_commit,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_data
`ifdef FIR_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam int AW     = clog2(TAPS);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int GROUPS = TAPS / 4;
  localparam int SUM_W  = DATA_W + COEF_W + 2;

  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [DATA_W-1:0] dline  [TAPS];
  logic                     v1;
  logic [GROUPS-1:0]        gv;
  logic signed [SUM_W-1:0]  gsum   [GROUPS];
  logic                     v3;
  logic signed [ACC_W-1:0]  acc;
  logic [OUT_W-1:0]         y_next;
  logic                     ovf;

  // A write in the commit cycle must land in the active bank too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= COEF_W'(def_coef(k));
        active[k] <= COEF_W'(def_coef(k));
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (coef_we && coef_addr == AW'(k))
          shadow[k] <= coef_wdata;
        if (coef_commit)
          active[k] <= (coef_we && coef_addr == AW'(k))
                     ? coef_wdata : shadow[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int k = 0; k < TAPS; k++) dline[k] <= '0;
    end else begin
      v1 <= in_valid & ~flush;
      if (flush) begin
        for (int k = 0; k < TAPS; k++) dline[k] <= '0;
      end else if (in_valid) begin
        dline[0] <= in_data;
        for (int k = 1; k < TAPS; k++) dline[k] <= dline[k-1];
      end
    end
  end

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic signed [DATA_W-1:0] gx [4];
    logic signed [COEF_W-1:0] gc [4];
    for (genvar i = 0; i < 4; i++) begin : g_tap
      assign gx[i] = dline[4*g+i];
      assign gc[i] = active[4*g+i];
    end
    fir_group_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W)
    ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (v1),
      .x         (gx),
      .c         (gc),
      .out_valid (gv[g]),
      .out_sum   (gsum[g])
    );
  end

  assign v3 = &gv;

  always_comb begin
    acc = '0;
    for (int g = 0; g < GROUPS; g++)
      acc = acc + ACC_W'(gsum[g]);
  end

`ifdef FIR_SAT_EN
  localparam int SH_W  = ACC_W - SHIFT;
  localparam int EXT_W = (SH_W > OUT_W) ? SH_W : OUT_W;

  logic signed [EXT_W-1:0] sh_ext;
  logic [EXT_W-OUT_W:0]    top_bits;

  // In range only if every bit above the output sign bit matches it.
  always_comb begin
    sh_ext   = EXT_W'(acc >>> SHIFT);
    top_bits = sh_ext[EXT_W-1:OUT_W-1];
    ovf      = !((&top_bits) || !(|top_bits));
    y_next   = sh_ext[OUT_W-1:0];
    if (ovf)
      y_next = sh_ext[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_flag <= 1'b0;
    else if (flush)
      sat_flag <= 1'b0;
    else if (v3 && ovf)
      sat_flag <= 1'b1;
  end
`else
  always_comb begin
    y_next = OUT_W'(acc >>> SHIFT);
    ovf    = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= v3 & ~flush;
      if (v3 && !flush)
        out_data <= y_next;
    end
  end

endmodule

// File: tb/tb_fir_param_pipe.sv
// Bench for fir_param_pipe: two instances (18-bit unshifted, 8-bit >>2)
// driven together and checked against a sample-history reference model.
module tb_fir_param_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        flush = 1'b0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [7:0]  coef_wdata = '0;
  logic        coef_commit = 1'b0;
  logic        a_v, b_v, a_sat, b_sat;
  logic [17:0] a_d;
  logic [7:0]  b_d;

  always #5 clk = ~clk;

  fir_param_pipe #(.DATA_W(8), .COEF_W(8), .TAPS(16),
                   .OUT_W(18), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .out_valid(a_v), .out_data(a_d)
`ifdef FIR_SAT_EN
    , .sat_flag(a_sat)
`endif
  );

  fir_param_pipe #(.DATA_W(8), .COEF_W(8), .TAPS(16),
                   .OUT_W(8), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .out_valid(b_v), .out_data(b_d)
`ifdef FIR_SAT_EN
    , .sat_flag(b_sat)
`endif
  );

`ifndef FIR_SAT_EN
  assign a_sat = 1'b0;
  assign b_sat = 1'b0;
`endif

  int DEF [16] = '{17, -41, 24, -58, -116, 86, -102, 58,
                   -16, 127, 15, -9, -21, -74, -68, -48};

  int     shadow [16];
  int     active [16];
  int     hist   [16];
  int     q_due  [$];
  longint q_acc  [$];
  int     edge_n = 0;
  int     chk = 0;
  int     bad = 0;
  logic        ev, esa, esb;
  logic [17:0] ea;
  logic [7:0]  eb;
  int     got [$];

  function automatic longint proj(input longint acc, input int ow,
                                  input int sh, output bit s);
    longint v, lim;
    v = acc >>> sh;
    lim = longint'(1) << (ow - 1);
    s = 1'b0;
`ifdef FIR_SAT_EN
    if (v > lim - 1) begin v = lim - 1; s = 1'b1; end
    else if (v < -lim) begin v = -lim; s = 1'b1; end
`else
    v = v & ((lim << 1) - 1);
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      shadow[k] = DEF[k];
      active[k] = DEF[k];
      hist[k] = 0;
    end
    q_due.delete();
    q_acc.delete();
    ev = 0; esa = 0; esb = 0; ea = '0; eb = '0;
  endtask

  // Drive one cycle, advance the model past the edge, sample at +1.
  task automatic step(input bit v, input int d, input bit fl = 0,
                      input bit we = 0, input int addr = 0,
                      input int wd = 0, input bit cm = 0);
    longint acc;
    bit s;
    in_valid = v; in_data = 8'(d); flush = fl;
    coef_we = we; coef_addr = 4'(addr);
    coef_wdata = 8'(wd); coef_commit = cm;
    @(posedge clk);
    edge_n++;
    if (we) shadow[addr] = wd;
    if (cm) active = shadow;
    if (fl) begin
      for (int k = 0; k < 16; k++) hist[k] = 0;
      while (q_due.size() > 0 && q_due[$] >= edge_n) begin
        void'(q_due.pop_back());
        void'(q_acc.pop_back());
      end
      esa = 0; esb = 0;
    end else if (v) begin
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      acc = 0;
      for (int k = 0; k < 16; k++) acc += longint'(active[k] * hist[k]);
      q_due.push_back(edge_n + 3);
      q_acc.push_back(acc);
    end
    ev = (q_due.size() > 0 && q_due[0] == edge_n);
    if (ev) begin
      void'(q_due.pop_front());
      acc = q_acc.pop_front();
      ea = 18'(proj(acc, 18, 0, s)); esa |= s;
      eb = 8'(proj(acc, 8, 2, s));   esb |= s;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    chk++;
    if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== 30'd0) begin
      bad++;
      $display("FAIL reset got v=%b/%b a=%0d b=%0d sat=%b/%b want 0",
               a_v, b_v, a_d, b_d, a_sat, b_sat);
    end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    int first;
    first = -1;
    got.delete();
    for (int i = 0; i < 24; i++) begin
      step(i < 16, (i == 0) ? 64 : 0);
      if (a_v && first < 0) first = i;
      if (a_v) got.push_back(int'($signed(a_d)));
      chk++;
      if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== {ev, ev, ea, eb, esa, esb}) begin
        bad++;
        $display("FAIL impulse edge=%0d got v=%b/%b a=%0d b=%0d want v=%b a=%0d b=%0d",
                 edge_n, a_v, b_v, $signed(a_d), $signed(b_d), ev, $signed(ea), $signed(eb));
      end
    end
    chk++;
    if (first != 3) begin
      bad++;
      $display("FAIL impulse_latency got=%0d want=3", first);
    end
    for (int k = 0; k < 16; k++) begin
      chk++;
      if (k >= got.size() || got[k] != 64 * DEF[k]) begin
        bad++;
        $display("FAIL impulse_tap k=%0d got=%0d want=%0d", k,
                 (k < got.size()) ? got[k] : 0, 64 * DEF[k]);
      end
    end
  endtask

  task automatic test_bubbles();
    int n;
    n = 0;
    got.delete();
    for (int i = 0; i < 40; i++) begin
      step((i % 2 == 0) && n < 16, (n == 0) ? 64 : 0);
      if (in_valid) n++;
      if (a_v) got.push_back(int'($signed(a_d)));
      chk++;
      if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== {ev, ev, ea, eb, esa, esb}) begin
        bad++;
        $display("FAIL bubbles edge=%0d got v=%b a=%0d want v=%b a=%0d",
                 edge_n, a_v, $signed(a_d), ev, $signed(ea));
      end
    end
    chk++;
    if (got.size() != 16) begin
      bad++;
      $display("FAIL bubbles_count got=%0d want=16", got.size());
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      chk++;
      if (got[k] != 64 * DEF[k]) begin
        bad++;
        $display("FAIL bubbles_tap k=%0d got=%0d want=%0d", k, got[k], 64 * DEF[k]);
      end
    end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 8)       step(1, int'($urandom_range(0, 255)) - 128);
      else if (i == 8) step(1, 99, 1);
      else             step(i < 14 ? 0 : (i < 30), (i == 14) ? 64 : 0);
      if (i >= 8 && i < 14 && a_v) pulses++;
      chk++;
      if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== {ev, ev, ea, eb, esa, esb}) begin
        bad++;
        $display("FAIL flush edge=%0d got v=%b a=%0d want v=%b a=%0d",
                 edge_n, a_v, $signed(a_d), ev, $signed(ea));
      end
      if (i == 17) begin
        chk++;
        if (int'($signed(a_d)) != 64 * DEF[0]) begin
          bad++;
          $display("FAIL flush_clean got=%0d want=%0d", $signed(a_d), 64 * DEF[0]);
        end
      end
    end
    chk++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL flush_drop got=%0d pulses want=0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    step(0, 0, 0, 1, 0, 55, 1);
    for (int i = 0; i < 6; i++) step(1, int'($urandom_range(0, 255)) - 128);
    #3 rst = 1'b1;
    #1;
    chk++;
    if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== 30'd0) begin
      bad++;
      $display("FAIL reset_mid got v=%b/%b a=%0d want v=0 a=0",
               a_v, b_v, $signed(a_d));
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step(i < 16, (i == 0) ? 64 : 0);
      if (a_v) got.push_back(int'($signed(a_d)));
      chk++;
      if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== {ev, ev, ea, eb, esa, esb}) begin
        bad++;
        $display("FAIL reset_mid edge=%0d got v=%b a=%0d want v=%b a=%0d",
                 edge_n, a_v, $signed(a_d), ev, $signed(ea));
      end
    end
    chk++;
    if (got.size() != 16 || got[0] != 64 * DEF[0] || got[9] != 64 * DEF[9]) begin
      bad++;
      $display("FAIL reset_defaults got n=%0d c0=%0d want n=16 c0=%0d",
               got.size(), (got.size() > 0) ? got[0] : 0, 64 * DEF[0]);
    end
  endtask

  task automatic test_commit();
    int pre [3] = '{170, -240, 0};
    got.delete();
    step(0, 0, 1);
    for (int k = 0; k < 16; k++) step(0, 0, 0, 1, k, 1);
    for (int i = 0; i < 6; i++) begin
      step(i < 3, 10);
      if (a_v) got.push_back(int'($signed(a_d)));
    end
    for (int k = 0; k < 3; k++) begin
      chk++;
      if (k >= got.size() || got[k] != pre[k]) begin
        bad++;
        $display("FAIL commit_pre k=%0d got=%0d want=%0d", k,
                 (k < got.size()) ? got[k] : 0, pre[k]);
      end
    end
    got.delete();
    step(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 24; i++) begin
      step(i < 20, 10);
      if (a_v) got.push_back(int'($signed(a_d)));
      chk++;
      if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== {ev, ev, ea, eb, esa, esb}) begin
        bad++;
        $display("FAIL commit edge=%0d got v=%b a=%0d want v=%b a=%0d",
                 edge_n, a_v, $signed(a_d), ev, $signed(ea));
      end
    end
    for (int k = 0; k < 20; k++) begin
      chk++;
      if (k >= got.size() || got[k] != 10 * ((k < 16) ? k + 1 : 16)) begin
        bad++;
        $display("FAIL commit_ramp k=%0d got=%0d want=%0d", k,
                 (k < got.size()) ? got[k] : 0, 10 * ((k < 16) ? k + 1 : 16));
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 16; k++) step(0, 0, 0, 1, k, 127, k == 15);
    for (int i = 0; i < 22; i++) begin
      step(i < 19, 127);
      chk++;
      if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== {ev, ev, ea, eb, esa, esb}) begin
        bad++;
        $display("FAIL saturation edge=%0d got v=%b b=%0d sat=%b want v=%b b=%0d sat=%b",
                 edge_n, b_v, $signed(b_d), b_sat, ev, $signed(eb), esb);
      end
    end
`ifdef FIR_SAT_EN
    chk++;
    if (b_d !== 8'd127 || b_sat !== 1'b1) begin
      bad++;
      $display("FAIL sat_clip got b=%0d sat=%b want b=127 sat=1", $signed(b_d), b_sat);
    end
`else
    chk++;
    if (b_d !== 8'd4) begin
      bad++;
      $display("FAIL sat_wrap got b=%0d want b=4", $signed(b_d));
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 24) == 0);
      chk++;
      if ({a_v, b_v, a_d, b_d, a_sat, b_sat} !== {ev, ev, ea, eb, esa, esb}) begin
        bad++;
        $display("FAIL random edge=%0d got v=%b/%b a=%0d b=%0d sat=%b/%b want v=%b a=%0d b=%0d sat=%b/%b",
                 edge_n, a_v, b_v, $signed(a_d), $signed(b_d), a_sat, b_sat,
                 ev, $signed(ea), $signed(eb), esa, esb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_bubbles();
    test_flush();
    test_reset_mid();
    test_commit();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", chk, bad);
    $finish;
  end

endmodule
